// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared encodings and default widths for the dual-core memory system
package mips_mc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      WAIT   = 2'd2,
      RESP   = 2'd3
   } state_t;

   localparam int DEF_ADDR_W = 12;
   localparam int DEF_DATA_W = 32;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - combinational two-requester round-robin grant
module rr_arb2 (
   input  logic req0,
   input  logic req1,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   assign grant_valid = req0 | req1;
   // On a tie the port that did not win last time goes next.
   assign grant_id    = (req0 & req1) ? ~last_grant : req1;

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter from two core caches onto one main-memory port
// Optional write-invalidate output enabled by MEM_BUS_ARB_INVAL_EN.
module mem_bus_arbiter
   import mips_mc_pkg::*;
#(
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              ack0,
   output logic              ack1,
   output logic              stall0,
   output logic              stall1,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rden,
   output logic              mem_wren,
   input  logic [DATA_W-1:0] mem_q,
   output logic [1:0]        inv_valid,
   output logic [ADDR_W-1:0] inv_addr
);

   state_t            state;
   logic              last_grant;
   logic              grant;
   logic              we_q;
   logic [2:0]        cnt;
   logic [DATA_W-1:0] rdata_q;
   logic [1:0]        ack_q;

   logic              grant_valid;
   logic              grant_id;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_arb2 u_arb (
      .req0        (req0),
      .req1        (req1),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id)
   );

   assign sel_we    = grant_id ? we1    : we0;
   assign sel_addr  = grant_id ? addr1  : addr0;
   assign sel_wdata = grant_id ? wdata1 : wdata0;

   // The memory-side registers double as the request latch: they are loaded
   // on the IDLE->ACCESS edge and cleared again when ACCESS ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         grant      <= 1'b0;
         we_q       <= 1'b0;
         cnt        <= 3'd0;
         rdata_q    <= '0;
         ack_q      <= 2'b00;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rden   <= 1'b0;
         mem_wren   <= 1'b0;
`ifdef MEM_BUS_ARB_INVAL_EN
         inv_valid  <= 2'b00;
         inv_addr   <= '0;
`endif
      end else begin
         ack_q     <= 2'b00;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_rden  <= 1'b0;
         mem_wren  <= 1'b0;
`ifdef MEM_BUS_ARB_INVAL_EN
         inv_valid <= 2'b00;
         inv_addr  <= '0;
`endif
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  grant      <= grant_id;
                  last_grant <= grant_id;
                  we_q       <= sel_we;
                  mem_addr   <= sel_addr;
                  mem_wdata  <= sel_wdata;
                  mem_wren   <= sel_we;
                  mem_rden   <= ~sel_we;
`ifdef MEM_BUS_ARB_INVAL_EN
                  if (sel_we) begin
                     inv_valid <= grant_id ? 2'b01 : 2'b10;
                     inv_addr  <= sel_addr;
                  end
`endif
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               if (we_q) begin
                  ack_q[grant] <= 1'b1;
                  state        <= RESP;
               end else begin
                  cnt   <= 3'(MEM_LAT);
                  state <= WAIT;
               end
            end
            WAIT: begin
               cnt <= cnt - 3'd1;
               if (cnt == 3'd1) begin
                  rdata_q      <= mem_q;
                  ack_q[grant] <= 1'b1;
                  state        <= RESP;
               end
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

`ifndef MEM_BUS_ARB_INVAL_EN
   assign inv_valid = 2'b00;
   assign inv_addr  = '0;
`endif

   assign ack0   = ack_q[0];
   assign ack1   = ack_q[1];
   assign rdata0 = rdata_q;
   assign rdata1 = rdata_q;
   assign stall0 = req0 & ~ack_q[0];
   assign stall1 = req1 & ~ack_q[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int AW = 12;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          req0, req1, we0, we1;
   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] wdata0, wdata1, mem_q;

   logic [DW-1:0] rdata0, rdata1, mem_wdata;
   logic          ack0, ack1, stall0, stall1, mem_rden, mem_wren;
   logic [AW-1:0] mem_addr, inv_addr;
   logic [1:0]    inv_valid;

   logic [DW-1:0] rdata0_l3, rdata1_l3, mem_wdata_l3;
   logic          ack0_l3, ack1_l3, stall0_l3, stall1_l3, mem_rden_l3, mem_wren_l3;
   logic [AW-1:0] mem_addr_l3, inv_addr_l3;
   logic [1:0]    inv_valid_l3;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1)) dut (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0), .rdata1(rdata1), .ack0(ack0), .ack1(ack1),
      .stall0(stall0), .stall1(stall1),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rden(mem_rden), .mem_wren(mem_wren),
      .mem_q(mem_q), .inv_valid(inv_valid), .inv_addr(inv_addr)
   );

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3)) dut3 (
      .clk(clk), .rst(rst),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .rdata0(rdata0_l3), .rdata1(rdata1_l3), .ack0(ack0_l3), .ack1(ack1_l3),
      .stall0(stall0_l3), .stall1(stall1_l3),
      .mem_addr(mem_addr_l3), .mem_wdata(mem_wdata_l3), .mem_rden(mem_rden_l3), .mem_wren(mem_wren_l3),
      .mem_q(mem_q), .inv_valid(inv_valid_l3), .inv_addr(inv_addr_l3)
   );

   task automatic do_reset();
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; mem_q = '0;
      #1 req0 = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ack0, ack1, mem_rden, mem_wren} !== 4'b0000) begin
            failures++; $display("FAIL reset_strobes c=%0d got=%b exp=0000", c, {ack0, ack1, mem_rden, mem_wren});
         end
         checks++;
         if ({mem_addr, mem_wdata, rdata0, inv_valid, inv_addr} !== '0) begin
            failures++; $display("FAIL reset_buses c=%0d addr=%h wdata=%h rdata=%h inv=%b", c, mem_addr, mem_wdata, rdata0, inv_valid);
         end
         checks++;
         if ({stall0, stall1} !== 2'b10) begin
            failures++; $display("FAIL reset_stall c=%0d got=%b exp=10", c, {stall0, stall1});
         end
      end
      req0 = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single_read();
      mem_q = 32'hDEADBEEF;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h010;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if (stall0 !== (c <= 2)) begin
            failures++; $display("FAIL rd_stall0 c=%0d got=%b exp=%b", c, stall0, (c <= 2));
         end
         checks++;
         if ({mem_rden, mem_wren} !== {(c == 1), 1'b0}) begin
            failures++; $display("FAIL rd_strobes c=%0d got=%b", c, {mem_rden, mem_wren});
         end
         checks++;
         if (mem_addr !== ((c == 1) ? 12'h010 : 12'h000)) begin
            failures++; $display("FAIL rd_addr c=%0d got=%h", c, mem_addr);
         end
         checks++;
         if ({ack0, ack1} !== {(c == 3), 1'b0}) begin
            failures++; $display("FAIL rd_ack c=%0d got=%b", c, {ack0, ack1});
         end
      end
      checks++;
      if (rdata0 !== 32'hDEADBEEF) begin
         failures++; $display("FAIL rd_rdata0 got=%h exp=deadbeef", rdata0);
      end
      @(posedge clk);
      #1 req0 = 1'b0;
   endtask

   task automatic test_single_write();
      logic [1:0]    exp_inv;
      logic [AW-1:0] exp_iaddr;
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h3FF; wdata1 = 32'h12345678;
      for (int c = 0; c <= 2; c++) begin
         @(negedge clk);
`ifdef MEM_BUS_ARB_INVAL_EN
         exp_inv   = (c == 1) ? 2'b01 : 2'b00;
         exp_iaddr = (c == 1) ? 12'h3FF : 12'h000;
`else
         exp_inv   = 2'b00;
         exp_iaddr = 12'h000;
`endif
         checks++;
         if ({mem_wren, mem_rden} !== {(c == 1), 1'b0}) begin
            failures++; $display("FAIL wr_strobes c=%0d got=%b", c, {mem_wren, mem_rden});
         end
         checks++;
         if ({mem_addr, mem_wdata} !== ((c == 1) ? {12'h3FF, 32'h12345678} : 44'h0)) begin
            failures++; $display("FAIL wr_bus c=%0d addr=%h wdata=%h", c, mem_addr, mem_wdata);
         end
         checks++;
         if ({ack1, ack0, stall1} !== {(c == 2), 1'b0, (c != 2)}) begin
            failures++; $display("FAIL wr_ack c=%0d got ack1/ack0/stall1=%b", c, {ack1, ack0, stall1});
         end
         checks++;
         if ({inv_valid, inv_addr} !== {exp_inv, exp_iaddr}) begin
            failures++; $display("FAIL wr_inv c=%0d got=%b/%h exp=%b/%h", c, inv_valid, inv_addr, exp_inv, exp_iaddr);
         end
      end
      @(posedge clk);
      #1 req1 = 1'b0; we1 = 1'b0;
   endtask

   task automatic test_simul_reads();
      do_reset();
      mem_q = 32'h000000A0;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h020;
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h030;
      for (int c = 0; c <= 7; c++) begin
         @(negedge clk);
         checks++;
         if ({ack0, ack1} !== {(c == 3), (c == 7)}) begin
            failures++; $display("FAIL sim_ack c=%0d got=%b", c, {ack0, ack1});
         end
         checks++;
         if (stall1 !== (c <= 6)) begin
            failures++; $display("FAIL sim_stall1 c=%0d got=%b", c, stall1);
         end
         checks++;
         if (mem_addr !== ((c == 1) ? 12'h020 : (c == 5) ? 12'h030 : 12'h000)) begin
            failures++; $display("FAIL sim_addr c=%0d got=%h", c, mem_addr);
         end
         if (c == 3) begin
            checks++;
            if (rdata0 !== 32'h000000A0) begin
               failures++; $display("FAIL sim_rdata0 got=%h exp=000000a0", rdata0);
            end
            @(posedge clk);
            #1 req0 = 1'b0; mem_q = 32'h000000B1;
         end
         if (c == 7) begin
            checks++;
            if (rdata1 !== 32'h000000B1) begin
               failures++; $display("FAIL sim_rdata1 got=%h exp=000000b1", rdata1);
            end
         end
      end
      @(posedge clk);
      #1 req1 = 1'b0;
   endtask

   task automatic test_back_to_back();
      req0 = 1'b1; we0 = 1'b1; addr0 = 12'h100; wdata0 = 32'hAAAA0000;
      req1 = 1'b1; we1 = 1'b1; addr1 = 12'h200; wdata1 = 32'h5555FFFF;
      for (int c = 0; c <= 11; c++) begin
         logic g;
         @(negedge clk);
         g = ((c / 3) % 2) == 1;
         checks++;
         if ({ack0, ack1} !== {(c % 3 == 2) && !g, (c % 3 == 2) && g}) begin
            failures++; $display("FAIL b2b_ack c=%0d got=%b", c, {ack0, ack1});
         end
         if (c % 3 == 1) begin
            checks++;
            if (mem_wdata !== (g ? 32'h5555FFFF : 32'hAAAA0000)) begin
               failures++; $display("FAIL b2b_wdata c=%0d got=%h", c, mem_wdata);
            end
         end
      end
      @(posedge clk);
      #1 req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
   endtask

   task automatic test_lat3();
      do_reset();
      mem_q = 32'h00001000;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h055;
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         checks++;
         if (ack0_l3 !== (c == 5)) begin
            failures++; $display("FAIL l3_ack0 c=%0d got=%b", c, ack0_l3);
         end
         checks++;
         if (mem_rden_l3 !== (c == 1)) begin
            failures++; $display("FAIL l3_rden c=%0d got=%b", c, mem_rden_l3);
         end
         if (c == 5) begin
            checks++;
            if (rdata0_l3 !== 32'h00001004) begin
               failures++; $display("FAIL l3_rdata got=%h exp=00001004", rdata0_l3);
            end
         end
         @(posedge clk);
         #1 mem_q = 32'h00001000 + 32'(c + 1);
      end
      req0 = 1'b0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      mem_q = 32'hCAFEF00D;
      req0 = 1'b1; we0 = 1'b0; addr0 = 12'h111;
      for (int c = 0; c <= 3; c++) @(negedge clk);
      checks++;
      if ({ack0, rdata0} !== {1'b1, 32'hCAFEF00D}) begin
         failures++; $display("FAIL rm_first got ack0=%b rdata0=%h", ack0, rdata0);
      end
      @(posedge clk);
      #1 req0 = 1'b0;
      @(posedge clk);
      #1 req0 = 1'b1; addr0 = 12'h222;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({mem_rden, mem_addr} !== {1'b1, 12'h222}) begin
         failures++; $display("FAIL rm_access got rden=%b addr=%h", mem_rden, mem_addr);
      end
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ack0, ack1, mem_rden, mem_wren, rdata0, mem_addr} !== '0) begin
         failures++; $display("FAIL rm_async got ack=%b rden=%b rdata0=%h", {ack0, ack1}, mem_rden, rdata0);
      end
      checks++;
      if (stall0 !== 1'b1) begin
         failures++; $display("FAIL rm_stall0 got=%b exp=1", stall0);
      end
      req1 = 1'b1; we1 = 1'b0; addr1 = 12'h333;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         checks++;
         if ({ack0, ack1} !== 2'b00) begin
            failures++; $display("FAIL rm_hold c=%0d got=%b", c, {ack0, ack1});
         end
      end
      @(posedge clk);
      #1 rst = 1'b0;
      for (int c = 0; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if ({ack0, ack1} !== {(c == 3), 1'b0}) begin
            failures++; $display("FAIL rm_reissue_ack c=%0d got=%b", c, {ack0, ack1});
         end
         checks++;
         if (mem_addr !== ((c == 1) ? 12'h222 : 12'h000)) begin
            failures++; $display("FAIL rm_reissue_addr c=%0d got=%h", c, mem_addr);
         end
      end
      @(posedge clk);
      #1 req0 = 1'b0; req1 = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_read();
      test_single_write();
      test_simul_reads();
      test_back_to_back();
      test_lat3();
      test_reset_mid();
      repeat (2) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port arbiter between the two MIPS cores' private caches and the single-port shared main memory. Each core's cache-miss/write-through path issues one request at a time. The arbiter grants round-robin, drives the synchronous main-memory port, and returns read data with a one-cycle ack. A core sees `stall` for as long as its request is pending.

## Interface
Parameters:
- `ADDR_W`, 12: word address width into main memory.
- `DATA_W`, 32: data word width.
- `MEM_LAT`, 1: main-memory read latency in cycles after the address-sampling edge. Legal range 1..7.

Ports:
- `clk` in 1: single clock, all state on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req0` / `req1` in 1: request from core 0 / core 1; held until ack.
- `we0` / `we1` in 1: 1 = write, 0 = read; stable while req high.
- `addr0` / `addr1` in ADDR_W: request address.
- `wdata0` / `wdata1` in DATA_W: write data.
- `rdata0` / `rdata1` out DATA_W: read data, valid while the matching ack is high.
- `ack0` / `ack1` out 1: one-cycle completion pulse.
- `stall0` / `stall1` out 1: `reqN & ~ackN`, combinational.
- `mem_addr` out ADDR_W: main-memory address.
- `mem_wdata` out DATA_W: main-memory write data.
- `mem_rden` / `mem_wren` out 1: main-memory strobes.
- `mem_q` in DATA_W: main-memory read data.
- `inv_valid` out 2: invalidate pulse to core 0 / core 1 cache.
- `inv_addr` out ADDR_W: address to invalidate.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- **IDLE:** if any req is high, pick a grant, latch `we`/`addr`/`wdata` from the granted port, update `last_grant`, then go to ACCESS.
- **Grant selection:** if only one port requests, grant that port. If both request, grant the port that is not `last_grant`.
- **ACCESS** (one cycle): `mem_addr`/`mem_wdata` = latched values, `mem_wren` = we, `mem_rden` = ~we.
  - Write: go to RESP.
  - Read: load the counter with MEM_LAT and go to WAIT.
- **WAIT:** decrement the counter each cycle. In the last cycle (counter == 1), capture `mem_q` into the rdata register and go to RESP.
- **RESP** (one cycle): `ack[grant]` = 1, `rdata[grant]` = captured word (writes return the last captured word, don't-care). Then go to IDLE.
- `rdata0`/`rdata1` are both driven from the single captured register; only the acked port's value is meaningful.
- Outside ACCESS, `mem_rden`, `mem_wren`, `mem_addr` and `mem_wdata` are 0.
- **Requests not serviced:** a req that rises while another grant is in flight stays pending with stall high; it is serviced from the next IDLE cycle.
- **Req dropped before ack:** protocol violation. The transaction still completes and the ack is still pulsed.
- **Reset (including mid-operation):**
  - Immediately: state = IDLE, `last_grant` = 1 (so core 0 wins the first tie), counter = 0, rdata register = 0.
  - All outputs go to 0; stall follows req.
  - An in-flight transaction is lost with no ack; the core re-issues after reset.

## Timing
- Cycle numbering: req first seen in IDLE = cycle 0.
- Read: ACCESS = cycle 1, WAIT = cycles 2..MEM_LAT+1, ack = cycle MEM_LAT+2.
- Write: ACCESS = cycle 1, ack = cycle 2.
- IDLE → IDLE back-to-back: one IDLE cycle after every RESP. Throughput:
  - One read per MEM_LAT+3 cycles.
  - One write per 3 cycles.
- `stall` drops in the ack cycle. The core may present a new request in the cycle after ack.

## Configuration
- Macro: `MEM_BUS_ARB_INVAL_EN`.
- **Defined:** in the ACCESS cycle of a write granted to core g, `inv_valid[1-g]` = 1 and `inv_addr` = latched address, for exactly one cycle. This is write-invalidate coherence for the other core's cache.
- **Undefined:** `inv_valid` = 0 and `inv_addr` = 0 constantly; no invalidate logic is synthesized.

## Structure
- Shared package `mips_mc_pkg` holds:
  - FSM state encoding (2-bit localparams IDLE = 0, ACCESS = 1, WAIT = 2, RESP = 3).
  - Default ADDR_W and DATA_W, which the caches and main-memory instances use too.
- One sub-module: `rr_arb2`, a combinational two-requester round-robin grant from (req0, req1, last_grant) producing (grant_valid, grant_id).
- FSM, latency counter (3 bits), latches and invalidate logic stay in the top module.

## Test plan
- Single read, MEM_LAT=1: `req0`=1, `we0`=0, `addr0`=0x010; memory returns 0xDEADBEEF → `mem_rden` high in cycle 1 with `mem_addr`=0x010, `ack0` high in cycle 3 with `rdata0`=0xDEADBEEF, `stall0` high in cycles 0..2.
- Single write: `req1`=1, `we1`=1, `addr1`=0x3FF, `wdata1`=0x12345678 → `mem_wren` high in cycle 1 with that address and data, `ack1` in cycle 2. With the macro: `inv_valid`=2'b01 and `inv_addr`=0x3FF in cycle 1.
- Simultaneous reads right after reset → core 0 served first (`ack0` at cycle 3), then core 1 (IDLE cycle 4, `ack1` at cycle 7). `stall1` is high throughout.
- Both cores request continuously for 4 transactions → grants alternate 0, 1, 0, 1. Neither core is acked twice in a row.
- MEM_LAT=3 read → ack at cycle 5, and `rdata` equals `mem_q` from the last WAIT cycle.
- `rst` asserted during WAIT → all outputs 0 in the same cycle and no ack. After release, a re-issued request completes normally with core 0 winning ties.
